button_poll_master: RTL and testbench



---
 rtl/button_poll_master_pkg.sv | 31 +++
 rtl/button_poll_master_if.sv | 30 +++
 rtl/button_poll_master_debounce.sv | 54 +++++
 rtl/button_poll_master.sv | 121 ++++++++++++
 tb/tb_button_poll_master.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/button_poll_master_pkg.sv
// button_pkg
//   Shared definitions for the push-button polling master:
//   - poll_state_t : poll sequencer states
//   - PIO_DATA_ADDR: word address of the button PIO data register
//   - clog2()      : ceil-log2 helper used to size the poll divider
package button_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        UPD
    } poll_state_t;

    localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

    // Never returns less than 1, so a counter sized with it always has at
    // least one bit.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/button_poll_master_if.sv
// button_poll_master_if
//   Avalon-MM read-only link between the polling master and the button PIO.
//   Signals:
//     avm_address     word address (master -> slave)
//     avm_read        read request (master -> slave)
//     avm_waitrequest slave stall  (slave -> master)
//     avm_readdata    read data, fixed latency 1 (slave -> master)
//   Modports: master (polling initiator), slave (PIO side).
interface button_poll_master_if;

    logic [1:0]  avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata
    );

endinterface

// File: rtl/button_poll_master_debounce.sv
// button_debounce_bit
//   Debouncer for one button bit. A new polled sample is presented with
//   'update' high for one cycle; the stable level only changes after DEB_N
//   consecutive samples disagree with it.
//   Ports:
//     clk, reset_n : clock, asynchronous active-low reset
//     update       : one-cycle strobe, 'sample' is valid
//     sample       : polled bit, 1 = pressed
//     level        : debounced level, 1 = pressed
//     press        : one-cycle pulse on level 0 -> 1
//     rel          : one-cycle pulse on level 1 -> 0
module button_debounce_bit #(
    parameter int DEB_N = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic update,
    input  logic sample,
    output logic level,
    output logic press,
    output logic rel
);

    localparam logic [3:0] CNT_LAST = 4'(DEB_N - 1);

    logic [3:0] cnt;

    // cnt counts consecutive disagreeing samples; any agreeing sample
    // restarts the run, so short glitches never reach CNT_LAST.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
        end else begin
            press <= 1'b0;
            rel   <= 1'b0;
            if (update) begin
                if (sample == level) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    level <= sample;
                    cnt   <= '0;
                    press <= sample;
                    rel   <= ~sample;
                end else begin
                    cnt <= cnt + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/button_poll_master.sv
// button_poll_master
//   Avalon-MM initiator that periodically reads the push-button PIO data
//   register, debounces the sampled bits and reports levels, press/release
//   pulses, sticky press flags and an interrupt.
//   Ports:
//     clk, reset_n : clock, asynchronous active-low reset
//     enable       : polling enable
//     bus          : Avalon-MM master link to the button PIO
//     btn_state    : debounced level, 1 = pressed
//     btn_press    : one-cycle pulse on debounced 0 -> 1
//     btn_release  : one-cycle pulse on debounced 1 -> 0
//     event_flags  : sticky press flags
//     event_clr    : per-bit flag clear
//     irq          : registered OR of event_flags
module button_poll_master
    import button_pkg::*;
#(
    parameter int         WIDTH      = 4,
    parameter int         POLL_DIV   = 50000,
    parameter int         DEB_N      = 4,
    parameter bit         ACTIVE_LOW = 1'b1,
    parameter logic [1:0] PIO_ADDR   = PIO_DATA_ADDR
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    button_poll_master_if.master bus,
    output logic [WIDTH-1:0]     btn_state,
    output logic [WIDTH-1:0]     btn_press,
    output logic [WIDTH-1:0]     btn_release,
    output logic [WIDTH-1:0]     event_flags,
    input  logic [WIDTH-1:0]     event_clr,
    output logic                 irq
);

    localparam int             DIV_W    = clog2(POLL_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(POLL_DIV - 1);

    poll_state_t      state;
    logic [DIV_W-1:0] div_cnt;
    logic             read_q;
    logic [WIDTH-1:0] sample;
    logic             upd_en;

    // Only the low WIDTH bits of the PIO word carry buttons.
    logic unused_readdata;
    assign unused_readdata = ^bus.avm_readdata;

    assign bus.avm_address = PIO_ADDR;
    assign bus.avm_read    = read_q;
    assign upd_en          = (state == UPD);

    // The divider only advances in IDLE, so IDLE lasts exactly POLL_DIV
    // cycles and the whole poll takes POLL_DIV+3 without stalls. Enable is
    // looked at only in IDLE, so a poll in flight always completes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            div_cnt <= '0;
            read_q  <= 1'b0;
            sample  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!enable) begin
                        div_cnt <= '0;
                    end else if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        state   <= REQ;
                        read_q  <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                REQ: begin
                    if (!bus.avm_waitrequest) begin
                        state  <= WAIT;
                        read_q <= 1'b0;
                    end
                end
                WAIT: begin
                    sample <= bus.avm_readdata[WIDTH-1:0] ^ {WIDTH{ACTIVE_LOW}};
                    state  <= UPD;
                end
                UPD: begin
                    state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    read_q <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_deb
        button_debounce_bit #(
            .DEB_N (DEB_N)
        ) u_deb (
            .clk     (clk),
            .reset_n (reset_n),
            .update  (upd_en),
            .sample  (sample[i]),
            .level   (btn_state[i]),
            .press   (btn_press[i]),
            .rel     (btn_release[i])
        );
    end

    // A press landing in the same cycle as its clear keeps the flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            event_flags <= '0;
            irq         <= 1'b0;
        end else begin
            event_flags <= (event_flags & ~event_clr) | btn_press;
            irq         <= |event_flags;
        end
    end

endmodule

// File: tb/tb_button_poll_master.sv
// tb_button_poll_master
//   Randomised self-checking bench for button_poll_master. A
//   transaction-level model keeps the history of polled samples and
//   decides debounced levels from the last DEB_N samples of each bit.
module tb_button_poll_master;

    localparam int WIDTH      = 4;
    localparam int POLL_DIV   = 8;
    localparam int DEB_N      = 4;
    localparam bit ACTIVE_LOW = 1'b1;

    logic       clk;
    logic       reset_n;
    logic       enable;
    logic [3:0] btn_state;
    logic [3:0] btn_press;
    logic [3:0] btn_release;
    logic [3:0] event_flags;
    logic [3:0] event_clr;
    logic       irq;

    int compares = 0;
    int errors   = 0;
    int cyc      = 0;

    logic [3:0] hist[$];
    int         last_chg[4];
    logic [3:0] m_state;
    logic [3:0] m_press;
    logic [3:0] m_rel;
    logic [3:0] m_flags;

    button_poll_master_if bus();

    button_poll_master #(
        .WIDTH      (WIDTH),
        .POLL_DIV   (POLL_DIV),
        .DEB_N      (DEB_N),
        .ACTIVE_LOW (ACTIVE_LOW),
        .PIO_ADDR   (2'd0)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .bus         (bus),
        .btn_state   (btn_state),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .event_flags (event_flags),
        .event_clr   (event_clr),
        .irq         (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time %0t exceeded required bound", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < 4; i++) last_chg[i] = 0;
        m_state = '0;
        m_press = '0;
        m_rel   = '0;
        m_flags = '0;
    endtask

    // A bit flips once its last DEB_N samples since the previous flip all
    // disagree with the current level.
    task automatic model_poll(input logic [3:0] raw);
        logic [3:0] smp;
        bit         all_diff;
        smp = raw ^ {4{ACTIVE_LOW}};
        hist.push_back(smp);
        m_press = '0;
        m_rel   = '0;
        for (int i = 0; i < 4; i++) begin
            if (hist.size() - last_chg[i] >= DEB_N) begin
                all_diff = 1'b1;
                for (int k = 1; k <= DEB_N; k++)
                    if (hist[hist.size() - k][i] == m_state[i]) all_diff = 1'b0;
                if (all_diff) begin
                    m_state[i]  = smp[i];
                    m_press[i]  = smp[i];
                    m_rel[i]    = ~smp[i];
                    last_chg[i] = hist.size();
                end
            end
        end
        m_flags = m_flags | m_press;
    endtask

    // Plays the PIO slave for one poll; ends in the cycle after UPD.
    task automatic do_poll(input logic [3:0] raw, input int stall,
                           output int read_cycles, output int start_cyc,
                           output bit side_ok);
        int n;
        n           = 0;
        read_cycles = 0;
        side_ok     = 1'b1;
        start_cyc   = cyc;
        bus.avm_waitrequest = (stall > 0);
        while (bus.avm_read !== 1'b1 && n < POLL_DIV + 40) begin
            tick();
            n++;
        end
        if (bus.avm_read !== 1'b1) begin
            compares++;
            errors++;
            $display("[TB] FAIL poll_timeout: avm_read=%b after %0d cycles, required 1", bus.avm_read, n);
            bus.avm_waitrequest = 1'b0;
            return;
        end
        start_cyc = cyc;
        for (int s = 0; s < stall; s++) begin
            if (bus.avm_read === 1'b1 && bus.avm_address === 2'd0) read_cycles++;
            bus.avm_readdata = $urandom();
            tick();
        end
        bus.avm_waitrequest = 1'b0;
        if (bus.avm_read === 1'b1 && bus.avm_address === 2'd0) read_cycles++;
        tick();
        if (bus.avm_read !== 1'b0) side_ok = 1'b0;
        bus.avm_readdata = ($urandom() & 32'hFFFF_FFF0) | {28'd0, raw};
        tick();
        if (bus.avm_read !== 1'b0) side_ok = 1'b0;
        bus.avm_readdata = $urandom();
        tick();
        if (bus.avm_read !== 1'b0) side_ok = 1'b0;
        model_poll(raw);
    endtask

    task automatic test_reset();
        reset_n             = 1'b0;
        enable              = 1'b0;
        event_clr           = '0;
        bus.avm_waitrequest = 1'b0;
        bus.avm_readdata    = 32'hFFFF_FFFF;
        model_reset();
        tick();
        tick();
        compares++; if (btn_state !== 4'h0)   begin errors++; $display("[TB] FAIL reset_state: got %h required 0", btn_state); end
        compares++; if (btn_press !== 4'h0)   begin errors++; $display("[TB] FAIL reset_press: got %h required 0", btn_press); end
        compares++; if (btn_release !== 4'h0) begin errors++; $display("[TB] FAIL reset_release: got %h required 0", btn_release); end
        compares++; if (event_flags !== 4'h0) begin errors++; $display("[TB] FAIL reset_flags: got %h required 0", event_flags); end
        compares++; if (irq !== 1'b0)         begin errors++; $display("[TB] FAIL reset_irq: got %b required 0", irq); end
        compares++; if (bus.avm_read !== 1'b0) begin errors++; $display("[TB] FAIL reset_read: got %b required 0", bus.avm_read); end
        reset_n = 1'b1;
        enable  = 1'b1;
    endtask

    task automatic test_idle_released();
        int rc, st, prev;
        bit ok;
        prev = -1;
        for (int p = 0; p < 3; p++) begin
            do_poll(4'hF, 0, rc, st, ok);
            compares++; if (rc !== 1) begin errors++; $display("[TB] FAIL idle_read_width: got %0d required 1", rc); end
            compares++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL idle_read_outside_req: got %b required 1", ok); end
            compares++; if (btn_state !== m_state) begin errors++; $display("[TB] FAIL idle_state: got %h required %h", btn_state, m_state); end
            compares++; if ((btn_press | btn_release) !== 4'h0) begin errors++; $display("[TB] FAIL idle_pulses: got %h/%h required 0/0", btn_press, btn_release); end
            if (prev >= 0) begin
                compares++; if (st - prev !== POLL_DIV + 3) begin errors++; $display("[TB] FAIL poll_period: got %0d required %0d", st - prev, POLL_DIV + 3); end
            end
            prev = st;
        end
    endtask

    task automatic test_press();
        int rc, st;
        bit ok;
        for (int p = 0; p < 4; p++) begin
            do_poll(4'hE, 0, rc, st, ok);
            compares++; if (btn_state !== m_state) begin errors++; $display("[TB] FAIL press_state poll %0d: got %h required %h", p, btn_state, m_state); end
            compares++; if (btn_press !== m_press) begin errors++; $display("[TB] FAIL press_pulse poll %0d: got %h required %h", p, btn_press, m_press); end
        end
        compares++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL press_irq_early: got %b required 0", irq); end
        tick();
        compares++; if (btn_press !== 4'h0) begin errors++; $display("[TB] FAIL press_pulse_width: got %h required 0", btn_press); end
        compares++; if (event_flags !== m_flags) begin errors++; $display("[TB] FAIL press_flags: got %h required %h", event_flags, m_flags); end
        tick();
        compares++; if (irq !== 1'b1) begin errors++; $display("[TB] FAIL press_irq: got %b required 1", irq); end
    endtask

    task automatic test_glitch();
        int rc, st;
        bit ok;
        logic [3:0] pattern[4];
        pattern = '{4'hC, 4'hC, 4'hC, 4'hE};
        for (int p = 0; p < 4; p++) begin
            do_poll(pattern[p], 0, rc, st, ok);
            compares++; if (btn_state !== m_state) begin errors++; $display("[TB] FAIL glitch_state poll %0d: got %h required %h", p, btn_state, m_state); end
            compares++; if (btn_press !== 4'h0) begin errors++; $display("[TB] FAIL glitch_press poll %0d: got %h required 0", p, btn_press); end
        end
        // The earlier 3-sample run must not count toward a fresh run.
        for (int p = 0; p < 3; p++) begin
            do_poll(4'hC, 0, rc, st, ok);
            compares++; if (btn_state !== m_state) begin errors++; $display("[TB] FAIL glitch_restart poll %0d: got %h required %h", p, btn_state, m_state); end
        end
        do_poll(4'hE, 0, rc, st, ok);
    endtask

    task automatic test_clear_collision();
        int rc, st;
        bit ok;
        for (int p = 0; p < 4; p++) do_poll(4'hF, 0, rc, st, ok);
        compares++; if (btn_release !== m_rel) begin errors++; $display("[TB] FAIL clr_release: got %h required %h", btn_release, m_rel); end
        compares++; if (btn_state !== m_state) begin errors++; $display("[TB] FAIL clr_released_state: got %h required %h", btn_state, m_state); end
        for (int p = 0; p < 4; p++) do_poll(4'hE, 0, rc, st, ok);
        compares++; if (btn_press !== m_press) begin errors++; $display("[TB] FAIL clr_press: got %h required %h", btn_press, m_press); end
        event_clr = 4'h1;
        tick();
        event_clr = 4'h0;
        m_flags = (m_flags & ~4'h1) | m_press;
        compares++; if (event_flags !== m_flags) begin errors++; $display("[TB] FAIL clr_set_wins: got %h required %h", event_flags, m_flags); end
        tick();
        event_clr = m_flags;
        tick();
        event_clr = 4'h0;
        m_flags = '0;
        compares++; if (event_flags !== 4'h0) begin errors++; $display("[TB] FAIL clr_alone: got %h required 0", event_flags); end
        tick();
        compares++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL clr_irq_fall: got %b required 0", irq); end
    endtask

    task automatic test_stall();
        int rc, st;
        bit ok;
        for (int p = 0; p < 4; p++) begin
            do_poll(4'hA, 5, rc, st, ok);
            compares++; if (rc !== 6) begin errors++; $display("[TB] FAIL stall_read_hold: got %0d cycles required 6", rc); end
            compares++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL stall_read_outside_req: got %b required 1", ok); end
            compares++; if (btn_state !== m_state) begin errors++; $display("[TB] FAIL stall_state poll %0d: got %h required %h", p, btn_state, m_state); end
            compares++; if (btn_press !== m_press) begin errors++; $display("[TB] FAIL stall_press poll %0d: got %h required %h", p, btn_press, m_press); end
        end
    endtask

    task automatic test_enable_drop();
        int n;
        n = 0;
        bus.avm_waitrequest = 1'b0;
        while (bus.avm_read !== 1'b1 && n < POLL_DIV + 40) begin tick(); n++; end
        compares++; if (bus.avm_read !== 1'b1) begin errors++; $display("[TB] FAIL en_first_read: got %b required 1", bus.avm_read); end
        tick();
        enable = 1'b0;
        bus.avm_readdata = ($urandom() & 32'hFFFF_FFF0) | 32'hB;
        tick();
        bus.avm_readdata = $urandom();
        tick();
        model_poll(4'hB);
        compares++; if (btn_state !== m_state) begin errors++; $display("[TB] FAIL en_complete_state: got %h required %h", btn_state, m_state); end
        n = 0;
        for (int c = 0; c < 4 * POLL_DIV; c++) begin
            if (bus.avm_read === 1'b1) n++;
            tick();
        end
        compares++; if (n !== 0) begin errors++; $display("[TB] FAIL en_off_reads: got %0d required 0", n); end
        enable = 1'b1;
        n = 0;
        while (bus.avm_read !== 1'b1 && n < POLL_DIV + 40) begin tick(); n++; end
        compares++; if (n !== POLL_DIV) begin errors++; $display("[TB] FAIL en_restart_delay: got %0d required %0d", n, POLL_DIV); end
        tick();
        bus.avm_readdata = ($urandom() & 32'hFFFF_FFF0) | 32'hB;
        tick();
        bus.avm_readdata = $urandom();
        tick();
        model_poll(4'hB);
        compares++; if (btn_state !== m_state) begin errors++; $display("[TB] FAIL en_resume_state: got %h required %h", btn_state, m_state); end
    endtask

    task automatic test_random();
        int rc, st, stall;
        bit ok;
        logic [3:0] raw, clr;
        raw = 4'hF;
        for (int p = 0; p < 40; p++) begin
            if ($urandom_range(0, 2) == 0) raw = 4'($urandom_range(0, 15));
            stall = $urandom_range(0, 2);
            do_poll(raw, stall, rc, st, ok);
            compares++; if (rc !== stall + 1) begin errors++; $display("[TB] FAIL rnd_read_hold poll %0d: got %0d required %0d", p, rc, stall + 1); end
            compares++; if (btn_state !== m_state) begin errors++; $display("[TB] FAIL rnd_state poll %0d: got %h required %h", p, btn_state, m_state); end
            compares++; if (btn_press !== m_press) begin errors++; $display("[TB] FAIL rnd_press poll %0d: got %h required %h", p, btn_press, m_press); end
            compares++; if (btn_release !== m_rel) begin errors++; $display("[TB] FAIL rnd_release poll %0d: got %h required %h", p, btn_release, m_rel); end
            clr = 4'($urandom_range(0, 15));
            event_clr = clr;
            tick();
            event_clr = 4'h0;
            m_flags = (m_flags & ~clr) | m_press;
            compares++; if (event_flags !== m_flags) begin errors++; $display("[TB] FAIL rnd_flags poll %0d: got %h required %h", p, event_flags, m_flags); end
            tick();
            compares++; if (irq !== (|m_flags)) begin errors++; $display("[TB] FAIL rnd_irq poll %0d: got %b required %b", p, irq, |m_flags); end
        end
    endtask

    task automatic test_reset_mid();
        int rc, st, n;
        bit ok;
        for (int p = 0; p < 6; p++) do_poll(4'hC, 0, rc, st, ok);
        compares++; if (btn_state !== 4'h3) begin errors++; $display("[TB] FAIL rst_pre_state: got %h required 3", btn_state); end
        n = 0;
        while (bus.avm_read !== 1'b1 && n < POLL_DIV + 40) begin tick(); n++; end
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        compares++; if (btn_state !== 4'h0)   begin errors++; $display("[TB] FAIL rst_async_state: got %h required 0", btn_state); end
        compares++; if (event_flags !== 4'h0) begin errors++; $display("[TB] FAIL rst_async_flags: got %h required 0", event_flags); end
        compares++; if (irq !== 1'b0)         begin errors++; $display("[TB] FAIL rst_async_irq: got %b required 0", irq); end
        compares++; if ((btn_press | btn_release) !== 4'h0) begin errors++; $display("[TB] FAIL rst_async_pulses: got %h/%h required 0/0", btn_press, btn_release); end
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        n = 0;
        while (bus.avm_read !== 1'b1 && n < 3 * POLL_DIV) begin tick(); n++; end
        compares++; if (n !== POLL_DIV) begin errors++; $display("[TB] FAIL rst_restart_delay: got %0d required %0d", n, POLL_DIV); end
    endtask

    initial begin
        $display("[TB] start");
        test_reset();
        test_idle_released();
        test_press();
        test_glitch();
        test_clear_collision();
        test_stall();
        test_enable_drop();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
        $finish;
    end

endmodule
